// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle unsigned multiply / restoring divide for the EX stage.
// Define MULDIV_DIV_EN to build the divider; without it DIVU completes with zero results.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign accept = start_i & ~flush_i & (state_q != ST_RUN);

  // {acc_hi, acc_lo} starts as {0, multiplier}; the consumed multiplier bits shift out
  // of acc_lo as product bits shift in from the top.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_hi, div_lo;

  // {acc_hi, acc_lo} = {remainder, dividend/quotient}; bit WIDTH of the difference is the borrow.
  always_comb begin
    div_diff = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_hi = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
    end else begin
      div_hi = div_diff[WIDTH-1:0];
    end
    div_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  assign step_hi = op_q ? div_hi : mul_hi;
  assign step_lo = op_q ? div_lo : mul_lo;
`else
  assign step_hi = op_q ? '0 : mul_hi;
  assign step_lo = op_q ? '0 : mul_lo;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (accept) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            op_d     = op_i;
            opnd_d   = op_i ? b_i : a_i;
            acc_hi_d = '0;
            acc_lo_d = op_i ? a_i : b_i;
          end
        end
        ST_RUN: begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            lo_d    = step_lo;
            hi_d    = step_hi;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign stall_o = (state_q == ST_RUN) | accept;
  assign lo_o    = lo_q;
  assign hi_o    = hi_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        op_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] lo_o, hi_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .busy_o(busy_o),
    .stall_o(stall_o), .done_o(done_o), .lo_o(lo_o), .hi_o(hi_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo}
  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op) return {32'b0, a} * {32'b0, b};
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    check_eq("stall_on_accept", {63'b0, stall_o}, 64'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Counts edges from the accept edge (already_edges so far) until done_o is seen.
  task automatic wait_done(input int already_edges, output int edges);
    edges = already_edges;
    while (!done_o && edges < 100) begin
      tick();
      edges++;
    end
    if (!done_o) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_done_cycle(input logic op, input logic [31:0] a, input logic [31:0] b, input int edges);
    logic [63:0] exp;
    exp = model(op, a, b);
    check_eq("latency", 64'(edges), 64'd33);
    check_eq("done", {63'b0, done_o}, 64'd1);
    check_eq("busy_in_done", {63'b0, busy_o}, 64'd0);
    check_eq("lo", {32'b0, lo_o}, {32'b0, exp[31:0]});
    check_eq("hi", {32'b0, hi_o}, {32'b0, exp[63:32]});
    $display("[TB] op=%0d a=%08h b=%08h -> lo=%08h hi=%08h after %0d cycles", op, a, b, lo_o, hi_o, edges);
  endtask

  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(op, a, b);
    wait_done(1, n);
    check_done_cycle(op, a, b, n);
    check_eq("stall_in_done", {63'b0, stall_o}, 64'd0);
    tick();
    check_eq("done_one_cycle", {63'b0, done_o}, 64'd0);
  endtask

  task automatic count_dones(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done_o) dones++;
    end
  endtask

  initial begin
    int n;
    int dones;
    logic [63:0] prev;
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic rop;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", {63'b0, busy_o}, 64'd0);
    check_eq("rst_done", {63'b0, done_o}, 64'd0);
    check_eq("rst_lo", {32'b0, lo_o}, 64'd0);
    check_eq("rst_hi", {32'b0, hi_o}, 64'd0);
    rst_i = 1'b1;
    tick();

    // Directed cases
    run_op(1'b0, 32'd7, 32'd6);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd100, 32'd7);
    run_op(1'b1, 32'h1234_5678, 32'd0);

    // Flush at iteration 10: no done, outputs keep previous result
    run_op(1'b0, 32'd7, 32'd6);
    prev = model(1'b0, 32'd7, 32'd6);
    issue(1'b0, 32'd3, 32'd5);
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_eq("flush_busy", {63'b0, busy_o}, 64'd0);
    check_eq("flush_done", {63'b0, done_o}, 64'd0);
    count_dones(40, dones);
    check_eq("flush_no_done", 64'(dones), 64'd0);
    check_eq("flush_lo_kept", {32'b0, lo_o}, {32'b0, prev[31:0]});
    check_eq("flush_hi_kept", {32'b0, hi_o}, {32'b0, prev[63:32]});
    $display("[TB] flush during MUL 3x5 -> lo=%08h hi=%08h", lo_o, hi_o);

    // Start pulse during RUN is ignored
    issue(1'b0, 32'd11, 32'd13);
    repeat (5) tick();
    start_i = 1'b1; op_i = 1'b1; a_i = 32'd999; b_i = 32'd3;
    tick();
    start_i = 1'b0;
    check_eq("run_start_busy", {63'b0, busy_o}, 64'd1);
    wait_done(7, n);
    check_done_cycle(1'b0, 32'd11, 32'd13, n);
    count_dones(40, dones);
    check_eq("run_start_no_extra_done", 64'(dones), 64'd0);

    // Back-to-back: DIVU 9/2 requested during the DONE cycle of MUL 2x3
    issue(1'b0, 32'd2, 32'd3);
    wait_done(1, n);
    check_done_cycle(1'b0, 32'd2, 32'd3, n);
    start_i = 1'b1; op_i = 1'b1; a_i = 32'd9; b_i = 32'd2;
    #1;
    check_eq("b2b_stall_in_done", {63'b0, stall_o}, 64'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check_eq("b2b_no_bubble", {63'b0, busy_o}, 64'd1);
    wait_done(1, n);
    check_done_cycle(1'b1, 32'd9, 32'd2, n);
    tick();

    // Asynchronous reset mid-RUN
    issue(1'b0, 32'd123, 32'd456);
    repeat (10) tick();
    #2;
    rst_i = 1'b0;
    #1;
    check_eq("arst_busy", {63'b0, busy_o}, 64'd0);
    check_eq("arst_done", {63'b0, done_o}, 64'd0);
    check_eq("arst_stall", {63'b0, stall_o}, 64'd0);
    check_eq("arst_lo", {32'b0, lo_o}, 64'd0);
    check_eq("arst_hi", {32'b0, hi_o}, 64'd0);
    $display("[TB] async reset mid-RUN -> lo=%08h hi=%08h busy=%0d", lo_o, hi_o, busy_o);
    tick();
    rst_i = 1'b1;
    tick();
    run_op(1'b0, 32'd123, 32'd456);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 255);
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
      run_op(rop, ra, rb);
    end

    exp = model(1'b0, 32'd1, 32'd1);
    check_eq("model_sanity_final", {32'b0, 32'(exp[31:0])}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. It consumes the operand pair and the operation select latched by the ID/EX pipeline register and computes a 32×32 unsigned multiply, or a 32/32 unsigned divide, over 32 cycles. While it works it raises a stall that the hazard logic uses to freeze the IF/ID and ID/EX registers. Results go to the EX/MEM register once `done_o` pulses.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width. Only 32 is supported; iteration count equals `WIDTH`.

Ports:
- `clk_i`  in  1  pipeline clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request from EX decode; ID/EX holds a muldiv instruction.
- `op_i`  in  1  operation: 0 = MUL, 1 = DIVU.
- `a_i`  in  32  operand A (multiplicand / dividend), from ID/EX `a` output.
- `b_i`  in  32  operand B (multiplier / divisor), from ID/EX `b` output.
- `flush_i`  in  1  abort the current operation (branch/exception flush).
- `busy_o`  out  1  unit in RUN state.
- `stall_o`  out  1  hold request to hazard unit (drives ID/EX enable low).
- `done_o`  out  1  one-cycle pulse: results valid.
- `lo_o`  out  32  MUL: product[31:0]; DIVU: quotient.
- `hi_o`  out  32  MUL: product[63:32]; DIVU: remainder.

## Operation
- States: IDLE, RUN, DONE. `rst_i` low forces:
  - state IDLE, iteration counter 0;
  - `lo_o`/`hi_o` = 0, `busy_o`/`done_o` = 0.
- Accept: `start_i`=1 in IDLE or DONE with `flush_i`=0.
  - On that edge, `a_i`, `b_i` and `op_i` are captured, the counter is cleared, and state goes to RUN.
- `start_i` in RUN is ignored; operands are already captured.
- MUL: radix-2 shift-add over a 64-bit accumulator. One multiplier bit per RUN cycle, LSB first.
- DIVU: restoring division.
  - Each cycle shifts {rem, quot} left by 1 and trial-subtracts the divisor using a 33-bit subtract.
  - If the subtract does not borrow, the remainder takes the difference and the quotient LSB is set to 1.
- Divide by zero needs no special path. The algorithm yields quotient 0xFFFFFFFF and remainder equal to the dividend, and the unit must produce exactly that.
- When the counter reaches 31 on a RUN edge, state goes to DONE. That edge also loads `lo_o`/`hi_o` from the final datapath.
- DONE lasts one cycle, with `done_o`=1. It then goes to IDLE, or straight to RUN if a new start is accepted.
- `lo_o`/`hi_o` hold their value until the next DONE; they are not cleared on accept.
- `stall_o` = (state==RUN) | (start_i & (state==IDLE | state==DONE) & ~flush_i). It is combinational so ID/EX holds on the accept cycle.
- `flush_i`=1 in any state: next state is IDLE.
  - No `done_o` is produced and `lo_o`/`hi_o` are unchanged.
  - `flush_i` takes priority over `start_i` and over completion.

## Timing
- Accept edge E0. RUN iterations occur on edges E1..E32.
- `busy_o` is high from after E0 until E32.
- `done_o` is high for exactly the cycle between E32 and E33, with results valid in that cycle.
- `stall_o` is high from the accept cycle through the cycle before DONE. It is low in the DONE cycle, so ID/EX/EX-MEM capture the results at E33.
- Fixed latency of 33 cycles from accept to `done_o`, independent of operand values. There is no early termination.
- Back-to-back: a start accepted in the DONE cycle re-enters RUN at E33 with no IDLE bubble.
- Reset asserted mid-RUN aborts immediately and asynchronously. Every output takes its reset value before the next edge.

## Configuration
- `MULDIV_DIV_EN` defined: DIVU datapath compiled in, behaviour as above.
- `MULDIV_DIV_EN` undefined:
  - The divider logic is removed.
  - An accepted `op_i`=1 still runs the full 33-cycle sequence, for identical stall timing.
  - It completes with `lo_o` = 0 and `hi_o` = 0.
  - MUL is unaffected.

## Test plan
- MUL 7 × 6 -> `done_o` exactly 33 cycles after accept; `lo_o`=42, `hi_o`=0; `stall_o` low in the DONE cycle.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> `lo_o`=0x00000001, `hi_o`=0xFFFFFFFE.
- DIVU 100 / 7 -> `lo_o`=14, `hi_o`=2. DIVU 0x12345678 / 0 -> `lo_o`=0xFFFFFFFF, `hi_o`=0x12345678. Without `MULDIV_DIV_EN`: both divides give 0/0 after 33 cycles.
- Flush: accept MUL 3×5, assert `flush_i` at iteration 10 -> IDLE next cycle, no `done_o`, `lo_o`/`hi_o` keep their previous results. A `start_i` pulse during RUN is ignored, with no extra `done_o`.
- Back-to-back: second start (DIVU 9/2) held high during the DONE cycle of MUL 2×3.
  - First result: `lo_o`=6.
  - Second start is accepted with no bubble; second `done_o` arrives 33 cycles later with `lo_o`=4, `hi_o`=1.
- Reset: drop `rst_i` mid-RUN between edges -> outputs 0 and IDLE before the next edge. After release, `start_i` is accepted normally.
